// File: rtl/shift_divider_if.sv
// Start/busy/done handshake and operand/result bus for shift_divider.
interface shift_divider_if #(
    parameter int unsigned m = 4,
    parameter int unsigned n = 4
);
    logic             start;
    logic [m+n-1:0]   A;
    logic [n-1:0]     B;
    logic             busy;
    logic             done;
    logic [m+n-1:0]   Q;
    logic [n-1:0]     R;
    logic             dz;

    modport master (output start, A, B, input busy, done, Q, R, dz);
    modport slave  (input start, A, B, output busy, done, Q, R, dz);
endinterface

// File: rtl/shift_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro SHIFT_DIV_BYPASS_EN: A < B finishes in one cycle without iterating.
module shift_divider #(
    parameter int unsigned m = 4,
    parameter int unsigned n = 4
) (
    input logic clk,
    input logic rst,
    shift_divider_if.slave bus
);
    localparam int unsigned W    = m + n;
    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [n:0]      rem_q, rem_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [n-1:0]    div_q, div_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    q_q, q_d;
    logic [n-1:0]    r_q, r_d;
    logic            dz_q, dz_d;

    logic [n:0] shifted;
    logic [n:0] diff;
    logic       ge;

    // Dividend register doubles as the quotient: its MSB leaves into rem, the new bit enters the LSB.
    assign shifted = (rem_q << 1) | {{n{1'b0}}, dvd_q[W-1]};
    assign ge      = shifted >= {1'b0, div_q};
    assign diff    = shifted - {1'b0, div_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    dvd_d = bus.A;
                    div_d = bus.B;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.B == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = bus.A[n-1:0];
                        dz_d    = 1'b1;
                    end
`ifdef SHIFT_DIV_BYPASS_EN
                    else if (bus.A < W'(bus.B)) begin
                        state_d = StDone;
                        q_d     = '0;
                        r_d     = bus.A[n-1:0];
                        dz_d    = 1'b0;
                    end
`endif
                    else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                rem_d = ge ? diff : shifted;
                dvd_d = {dvd_q[W-2:0], ge};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    q_d     = {dvd_q[W-2:0], ge};
                    r_d     = rem_d[n-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy = (state_q == StBusy);
    assign bus.done = (state_q == StDone);
    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.dz   = dz_q;
endmodule

// File: tb/tb_shift_divider.sv
// Scoreboard bench for shift_divider: driver pushes expected results, monitor checks on done.
module tb_shift_divider;
    localparam int unsigned M = 4;
    localparam int unsigned N = 4;
    localparam int unsigned W = M + N;

    typedef struct {
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_divider_if #(.m(M), .n(N)) bus ();
    shift_divider #(.m(M), .n(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   busy_lo   = 1;
    int   busy_hi   = 0;
    int   last_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Must be called at a negedge; the following posedge is the accepting edge t0.
    task automatic issue(input logic [W-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   t0;
        int   lat;
        int   ai;
        int   bi;
        ai = int'(a);
        bi = int'(b);
        t0 = cyc + 1;
        if (bi == 0) begin
            e.q  = '1;
            e.r  = a[N-1:0];
            e.dz = 1'b1;
            lat  = 0;
        end else begin
            e.q  = W'(ai / bi);
            e.r  = N'(ai % bi);
            e.dz = 1'b0;
            lat  = W;
`ifdef SHIFT_DIV_BYPASS_EN
            if (ai < bi) lat = 0;
`endif
        end
        e.cyc = t0 + lat;
        sb.push_back(e);
        last_done = e.cyc;
        if (lat == 0) begin
            busy_lo = 1;
            busy_hi = 0;
        end else begin
            busy_lo = t0;
            busy_hi = t0 + W - 1;
        end
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        do @(negedge clk); while (cyc < last_done);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", bus.done, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("Q", bus.Q, e.q);
                        check("R", bus.R, e.r);
                        check("dz", bus.dz, e.dz);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    check("done_missing", bus.done, 1'b1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [W-1:0] a;
        logic [N-1:0] b;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_Q", bus.Q, 0);
        check("rst_R", bus.R, 0);
        check("rst_dz", bus.dz, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd200, 4'd7);
        wait_idle();
        issue(8'd255, 4'd1);
        wait_idle();
        issue(8'd100, 4'd10);   // issued in the DONE cycle, no idle gap
        wait_idle();
        issue(8'd15, 4'd0);
        wait_idle();
        issue(8'd3, 4'd9);
        wait_idle();

        // Start pulses while busy must be ignored
        issue(8'd200, 4'd7);
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = 8'd50;
            bus.B     = 4'd5;
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of an operation
        issue(8'd200, 4'd7);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_Q", bus.Q, 0);
        check("midrst_R", bus.R, 0);
        check("midrst_dz", bus.dz, 1'b0);
        sb.delete();
        busy_lo = 1;
        busy_hi = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        last_done = cyc;
        repeat (W + 4) @(negedge clk);
        issue(8'd81, 4'd9);
        wait_idle();

        repeat (40) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 15));
            issue(a, b);
            bus.A = W'($urandom);
            bus.B = N'($urandom);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
